// File: rtl/led_flash_pkg.sv
// Shared definitions for the LED flash sequencer: FSM state encoding,
// RGB colour constants and the next-enabled-colour search.
package led_flash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam logic [2:0] RGB_OFF = 3'b000;

    // Lowest enabled colour strictly above cur; RGB_OFF when none.
    // Passing cur = RGB_OFF yields the lowest enabled colour.
    function automatic logic [2:0] next_colour(input logic [6:0] mask,
                                               input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] c;
        r = RGB_OFF;
        // Scan downward so the lowest qualifying colour is the last written.
        for (int unsigned i = 7; i > 0; i--) begin
            c = 3'(i);
            if (mask[c - 3'd1] && (c > cur)) begin
                r = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_flash_sequencer_tick_prescaler.sv
// Clock prescaler for the LED flash sequencer.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   en    - count enable; counter is held at 0 while low
//   tick  - one-cycle pulse on terminal count TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || (r_cnt == TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = en && (r_cnt == TERM);

endmodule

// File: rtl/led_flash_sequencer.sv
// RGB LED flash sequencer: steps through the enabled colours, showing each
// for a programmed ON time followed by an optional OFF (blank) time, in
// continuous or one-shot mode. Times are in prescaler ticks.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start, stop  - single-cycle control requests (stop has priority)
//   one_shot     - 1 = single pass then done, 0 = loop
//   on_time      - ON ticks (0 treated as 1)
//   off_time     - OFF ticks (0 = no OFF phase)
//   colour_mask  - bit i enables colour i+1
//   rgb          - LED drive {R,G,B}
//   colour_idx   - current colour, 0 when idle
//   busy         - not idle
//   done         - one-cycle pulse at end of a one-shot pass
module led_flash_sequencer
    import led_flash_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4000,
    parameter int unsigned TIME_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              one_shot,
    input  logic [TIME_W-1:0] on_time,
    input  logic [TIME_W-1:0] off_time,
    input  logic [6:0]        colour_mask,
    output logic [2:0]        rgb,
    output logic [2:0]        colour_idx,
    output logic              busy,
    output logic              done
);

    state_t            r_state,    w_state_nxt;
    logic [2:0]        r_colour,   w_colour_nxt;
    logic [TIME_W-1:0] r_tcnt,     w_tcnt_nxt;
    logic [TIME_W-1:0] r_on_m1,    w_on_m1_nxt;
    logic [TIME_W-1:0] r_off,      w_off_nxt;
    logic [6:0]        r_mask,     w_mask_nxt;
    logic              r_one_shot, w_one_shot_nxt;
    logic              r_done,     w_done_nxt;

    logic              w_tick;
    logic              w_pre_en;
    logic [2:0]        w_step_colour;
    logic [2:0]        w_first_colour;

    // Gating with stop clears the prescaler on the stop edge; a normal
    // one-shot finish always lands on terminal count, which wraps to 0.
    // This keeps the prescaler at 0 throughout IDLE without a
    // combinational path through the next-state logic.
    assign w_pre_en = (r_state != ST_IDLE) && !stop;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_pre_en),
        .tick  (w_tick)
    );

    assign w_step_colour  = next_colour(r_mask, r_colour);
    assign w_first_colour = next_colour(r_mask, RGB_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_colour   <= RGB_OFF;
            r_tcnt     <= '0;
            r_on_m1    <= '0;
            r_off      <= '0;
            r_mask     <= '0;
            r_one_shot <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_colour   <= w_colour_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_on_m1    <= w_on_m1_nxt;
            r_off      <= w_off_nxt;
            r_mask     <= w_mask_nxt;
            r_one_shot <= w_one_shot_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_colour_nxt   = r_colour;
        w_tcnt_nxt     = r_tcnt;
        w_on_m1_nxt    = r_on_m1;
        w_off_nxt      = r_off;
        w_mask_nxt     = r_mask;
        w_one_shot_nxt = r_one_shot;
        w_done_nxt     = 1'b0;

        if (stop) begin
            w_state_nxt  = ST_IDLE;
            w_colour_nxt = RGB_OFF;
            w_tcnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start && (colour_mask != '0)) begin
                        w_on_m1_nxt    = (on_time == '0) ? '0 : on_time - TIME_W'(1);
                        w_off_nxt      = off_time;
                        w_mask_nxt     = colour_mask;
                        w_one_shot_nxt = one_shot;
                        w_colour_nxt   = next_colour(colour_mask, RGB_OFF);
                        w_tcnt_nxt     = '0;
                        w_state_nxt    = ST_ON;
                    end
                end
                ST_ON, ST_OFF: begin
                    if (w_tick) begin
                        if (((r_state == ST_ON)  && (r_tcnt == r_on_m1)) ||
                            ((r_state == ST_OFF) && (r_tcnt == r_off - TIME_W'(1)))) begin
                            w_tcnt_nxt = '0;
                            if ((r_state == ST_ON) && (r_off != '0)) begin
                                w_state_nxt = ST_OFF;
                            end else if (w_step_colour != RGB_OFF) begin
                                w_colour_nxt = w_step_colour;
                                w_state_nxt  = ST_ON;
                            end else if (r_one_shot) begin
                                w_colour_nxt = RGB_OFF;
                                w_state_nxt  = ST_IDLE;
                                w_done_nxt   = 1'b1;
                            end else begin
                                w_colour_nxt = w_first_colour;
                                w_state_nxt  = ST_ON;
                            end
                        end else begin
                            w_tcnt_nxt = r_tcnt + TIME_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_colour_nxt = RGB_OFF;
                    w_tcnt_nxt   = '0;
                end
            endcase
        end
    end

    assign rgb        = (r_state == ST_ON) ? r_colour : RGB_OFF;
    assign colour_idx = r_colour;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_led_flash_sequencer.sv
// Self-checking bench for led_flash_sequencer with TICK_DIV=4.
module tb_led_flash_sequencer;
    import led_flash_pkg::*;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        one_shot = 1'b0;
    logic [15:0] on_time = '0;
    logic [15:0] off_time = '0;
    logic [6:0]  colour_mask = '0;
    logic [2:0]  rgb;
    logic [2:0]  colour_idx;
    logic        busy;
    logic        done;
    logic [7:0]  w_obs;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    led_flash_sequencer #(
        .TICK_DIV (TD),
        .TIME_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .one_shot    (one_shot),
        .on_time     (on_time),
        .off_time    (off_time),
        .colour_mask (colour_mask),
        .rgb         (rgb),
        .colour_idx  (colour_idx),
        .busy        (busy),
        .done        (done)
    );

    // Observation word {rgb, colour_idx, busy, done}.
    assign w_obs = {rgb, colour_idx, busy, done};

    typedef struct {
        logic [6:0]  mask;
        logic [15:0] on_t;
        logic [15:0] off_t;
        logic        os;
        int          passes;
        int          restart_at;
        int          pass_len;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic push_pass(input vec_t v);
        int unsigned on_c;
        on_c = (v.on_t == 16'd0) ? 1 : int'(v.on_t);
        for (int c = 1; c <= 7; c++) begin
            logic [2:0] cc;
            cc = 3'(c);
            if (v.mask[3'(c - 1)]) begin
                for (int unsigned k = 0; k < on_c * TD; k++)
                    sb.push_back({cc, cc, 1'b1, 1'b0});
                for (int unsigned k = 0; k < int'(v.off_t) * TD; k++)
                    sb.push_back({3'b000, cc, 1'b1, 1'b0});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mask:7'h7F,       on_t:16'd2, off_t:16'd1, os:1'b0, passes:2, restart_at:0,  pass_len:84};
        vecs[1] = '{mask:7'b1000101,  on_t:16'd2, off_t:16'd1, os:1'b1, passes:1, restart_at:10, pass_len:36};
        vecs[2] = '{mask:7'b0000011,  on_t:16'd1, off_t:16'd0, os:1'b0, passes:3, restart_at:0,  pass_len:8};
        vecs[3] = '{mask:7'b0000001,  on_t:16'd0, off_t:16'd0, os:1'b1, passes:1, restart_at:0,  pass_len:4};
        vecs[4] = '{mask:7'b0000001,  on_t:16'd1, off_t:16'd1, os:1'b1, passes:1, restart_at:2,  pass_len:8};
        vecs[5] = '{mask:7'b0100000,  on_t:16'd1, off_t:16'd2, os:1'b0, passes:2, restart_at:5,  pass_len:12};
        vecs[6] = '{mask:7'b1010000,  on_t:16'd3, off_t:16'd0, os:1'b1, passes:1, restart_at:7,  pass_len:24};

        repeat (2) @(negedge clk);
        chk("reset_idle", {24'd0, w_obs}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_release", {24'd0, w_obs}, 32'h0);

        for (int s = 0; s < 7; s++) begin
            vec_t       v;
            int         idx;
            int         wrap_at;
            int         dcnt;
            logic [2:0] prev_rgb;
            logic [2:0] first;
            logic [7:0] e;
            v = vecs[s];
            sb.delete();
            for (int p = 0; p < (v.os ? 1 : v.passes); p++) push_pass(v);
            if (v.os) begin
                sb.push_back(8'h01);
                sb.push_back(8'h00);
                sb.push_back(8'h00);
            end
            first = 3'd0;
            for (int c = 7; c >= 1; c--) if (v.mask[3'(c - 1)]) first = 3'(c);

            colour_mask = v.mask;
            on_time     = v.on_t;
            off_time    = v.off_t;
            one_shot    = v.os;
            start       = 1'b1;
            @(negedge clk);
            start       = 1'b0;
            // Inputs changed while busy must not influence the sequence.
            colour_mask = 7'h2A;
            on_time     = 16'd3;
            off_time    = 16'd5;
            one_shot    = ~v.os;

            idx = 0; wrap_at = -1; dcnt = 0; prev_rgb = 3'd0;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("seq%0d_cyc%0d", s, idx), {24'd0, w_obs}, {24'd0, e});
                if (done) begin
                    dcnt++;
                    if (wrap_at < 0) wrap_at = idx;
                end
                if (!v.os && idx > 0 && rgb == first && prev_rgb != first && wrap_at < 0)
                    wrap_at = idx;
                prev_rgb = rgb;
                start = (v.restart_at != 0) && (idx == v.restart_at);
                idx++;
                if (sb.size() > 0) @(negedge clk);
            end
            start = 1'b0;
            chk($sformatf("seq%0d_pass_len", s), 32'(wrap_at), 32'(v.pass_len));
            chk($sformatf("seq%0d_done_cnt", s), 32'(dcnt), v.os ? 32'd1 : 32'd0);
            if (!v.os) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                chk($sformatf("seq%0d_stop_idle", s), {24'd0, w_obs}, 32'h0);
            end
            @(negedge clk);
            chk($sformatf("seq%0d_end_idle", s), {24'd0, w_obs}, 32'h0);
        end

        // start with empty mask
        colour_mask = 7'h00; on_time = 16'd1; off_time = 16'd1; one_shot = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mask0_idle", {24'd0, w_obs}, 32'h0);
        @(negedge clk);
        chk("mask0_idle2", {24'd0, w_obs}, 32'h0);

        // start and stop together in IDLE
        colour_mask = 7'h01;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", {24'd0, w_obs}, 32'h0);
        @(negedge clk);
        chk("start_stop_idle2", {24'd0, w_obs}, 32'h0);

        // stop during OFF
        colour_mask = 7'h01; on_time = 16'd1; off_time = 16'd2; one_shot = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("off_test_on", {24'd0, w_obs}, {24'd0, 3'b001, 3'b001, 1'b1, 1'b0});
        repeat (5) @(negedge clk);
        chk("off_test_in_off", {24'd0, w_obs}, {24'd0, 3'b000, 3'b001, 1'b1, 1'b0});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_in_off", {24'd0, w_obs}, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("stop_off_no_done%0d", k), {24'd0, w_obs}, 32'h0);
        end

        // asynchronous reset while ON with green
        colour_mask = 7'b0000010; on_time = 16'd5; off_time = 16'd0; one_shot = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_on", {24'd0, w_obs}, {24'd0, 3'b010, 3'b010, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {24'd0, w_obs}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle%0d", k), {24'd0, w_obs}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_flash_sequencer.md
Name: led_flash_sequencer

Overview:
Sequences a 3-bit RGB LED through up to seven colours, from 1 = blue to 7 = white. Each enabled colour is shown for a programmable ON time, then blanked for a programmable OFF time. Times are counted in ticks from an internal clock prescaler. The block sits between the board control logic (start/stop/config) and the LED pins, and runs in either continuous or one-shot mode.

Parameters:
TICK_DIV, 4000, clk cycles per time tick (1 ms at 4 MHz); must be >= 2.
TIME_W, 16, width of the on_time and off_time inputs.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to begin a sequence.
stop  input  1  single-cycle request to abort immediately.
one_shot  input  1  1 = run one pass and finish; 0 = loop forever.
on_time  input  TIME_W  ON duration in ticks; 0 is treated as 1.
off_time  input  TIME_W  OFF duration in ticks; 0 means no OFF phase.
colour_mask  input  7  bit i enables colour i+1.
rgb  output  3  LED drive, {R,G,B}; equals colour_idx during ON, 0 otherwise.
colour_idx  output  3  current colour, 1..7; 0 when idle.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a one-shot pass completes.

Behaviour:
- Reset (async assert, sync release): state IDLE; rgb=0, colour_idx=0, busy=0, done=0; prescaler and tick counter cleared.
- States: IDLE, ON, OFF.
- Start acceptance: start is accepted only in IDLE, with stop low and colour_mask != 0.
- On acceptance, the block:
  - latches on_time, off_time, colour_mask and one_shot;
  - sets colour_idx to the lowest enabled colour;
  - clears the prescaler and tick counter;
  - enters ON, so rgb is valid on the next cycle.
- Ignored starts: start while busy, or with mask=0, has no effect; done is not pulsed.
- Prescaler:
  - free-counts 0..TICK_DIV-1 while busy and emits a tick on the terminal count;
  - held at 0 in IDLE.
- ON phase: rgb = colour_idx for exactly max(on_time,1)*TICK_DIV cycles.
  - Latched off_time != 0: go to OFF, rgb=0.
  - Latched off_time == 0: advance straight to the next colour's ON phase, with no blank cycle.
- OFF phase: rgb=0 for exactly off_time*TICK_DIV cycles, then advance.
- Advance: colour_idx moves to the next higher enabled colour.
  - Past the highest enabled colour, continuous mode wraps to the lowest enabled colour.
  - Past the highest enabled colour, one-shot mode goes to IDLE: done=1 for one cycle, busy=0, colour_idx=0 in the same cycle.
- Tick counter: cleared on every phase change; compares against latched (time-1), with no overflow at the maximum value.
- stop: from any state, IDLE on the next cycle; rgb=0, no done pulse.
  - stop and start in the same cycle: stop wins and start is dropped.
- Input changes while busy: changes to on_time, off_time, mask or one_shot have no effect until the next accepted start.
- Single enabled colour: continuous mode toggles that colour ON/OFF (steady ON if off_time=0); one-shot mode runs exactly one ON+OFF.

Decomposition:
- Shared include package led_flash_pkg holds:
  - state encodings: ST_IDLE=2'd0, ST_ON=2'd1, ST_OFF=2'd2;
  - colour constants: BLUE=3'b001 … WHITE=3'b111;
  - the OFF value RGB_OFF=3'b000.
- One sub-module, tick_prescaler (parameter TICK_DIV; ports clk, rst_n, en, tick), isolates the divider. Next-enabled-colour search stays inline as a priority function.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset mid-ON: assert rst_n=0 while rgb=3'b010 -> rgb=0, busy=0, colour_idx=0 in the same cycle without a clock edge; after release, stays IDLE.
2. Continuous, mask=7'h7F, on=2, off=1:
   - rgb=1 for 8 cycles, then 0 for 4, then 2 … 7;
   - then wraps to 1 at cycle 84 after start+1;
   - done never pulses.
3. One-shot, mask=7'b1000101, on=2, off=1:
   - colours 1, 3, 7, each 8 cycles ON + 4 OFF;
   - done pulses exactly once 36 cycles after the first rgb cycle, with busy falling in that cycle.
4. off_time=0, mask=7'b0000011, on=1, continuous -> rgb sequence 1,1,1,1,2,2,2,2,1… with no zero cycles.
5. Handshake edges:
   - start with mask=0 -> no busy;
   - start while busy -> sequence unchanged;
   - start+stop same cycle in IDLE -> stays IDLE;
   - stop during OFF -> IDLE next cycle, no done.
6. on_time=0, off=0, one-shot, mask=7'b0000001 -> rgb=1 for exactly 4 cycles, then done, IDLE.
